stream_demux_1to4: RTL and testbench

- Registered 1-to-4 stream demultiplexer; the inverse of the team's 4:1 select mux.
- Takes one valid/ready input stream with a 2-bit select and routes each beat to one of four valid/ready output channels.
- Routing is locked per packet: select is sampled on the first beat and held until the s_last beat.
- Sits between a single producer and four downstream consumers.

---
 rtl/stream_demux_pkg.sv | 22 ++
 rtl/demux_out_slot.sv | 53 +++++
 rtl/stream_demux_1to4.sv | 103 ++++++++++
 tb/tb_stream_demux_1to4.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  // Channel count is fixed; the select width follows from it.
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  // IDLE samples the select on the next beat; LOCKED reuses the stored route.
  typedef enum logic {
    IDLE,
    LOCKED
  } demux_state_t;

  // One-hot decode of a channel select.
  function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage : stream_demux_pkg

// File: rtl/demux_out_slot.sv
// Single-entry output register slot for one demux channel.
// A load always wins over a drain, so a full slot can be refilled
// on the same cycle its consumer takes the current beat.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;

  // Next-state: load replaces contents, otherwise a taken beat empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule : demux_out_slot

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// The destination is sampled on the first beat of a packet and held until
// the last beat; each channel owns an independent one-entry output slot so a
// stalled consumer only blocks beats that are routed to it.
module stream_demux_1to4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data [N_OUT],
  output logic [N_OUT-1:0]  m_last,
  output logic              busy
);

  demux_state_t      state_q, state_d;
  logic [SEL_W-1:0]  route_q, route_d;
  logic [SEL_W-1:0]  target;
  logic              accept;
  logic [N_OUT-1:0]  load;

  // Destination of the current beat: live select in IDLE, stored route mid-packet.
  always_comb begin
    target = s_sel;
    if (state_q == LOCKED) begin
      target = route_q;
    end
  end

  // Accept whenever the target slot is empty or is being drained this cycle.
  assign s_ready = ~m_valid[target] | m_ready[target];
  assign accept  = s_valid & s_ready;

  // Steer an accepted beat into exactly one slot.
  always_comb begin
    load = '0;
    if (accept) begin
      load = sel_onehot(target);
    end
  end

  // Packet-lock FSM: capture the route on a first beat, release on the last.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          route_d = s_sel;
          if (!s_last) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && s_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and stored route registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  assign busy = (state_q == LOCKED);

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[g]),
      .in_data(s_data),
      .in_last(s_last),
      .ready  (m_ready[g]),
      .valid  (m_valid[g]),
      .data   (m_data[g]),
      .last   (m_last[g])
    );
  end

endmodule : stream_demux_1to4

// File: tb/tb_stream_demux_1to4.sv
// Self-checking bench for stream_demux_1to4: vector table plus scoreboard.
module tb_stream_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [1:0] s_sel;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data [4];
  logic [3:0] m_last;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [1:0] expChan;
    logic       expBusy;
  } vec_t;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
    logic       last;
  } exp_t;

  vec_t vecs [15];
  exp_t expQ [$];

  // Reference routing model
  logic       modelLocked = 1'b0;
  logic [1:0] modelRoute  = 2'd0;

  // Monitor history for output stability
  logic [3:0] prevStall = 4'b0;
  logic [7:0] prevData [4];
  logic [3:0] prevLast = 4'b0;

  stream_demux_1to4 #(.DATA_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .s_sel  (s_sel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model an accepted beat: decide its channel and queue the expected output.
  task automatic pushExpected(input logic [1:0] sel, input logic [7:0] data, input logic last);
    exp_t e;
    e.chan = modelLocked ? modelRoute : sel;
    e.data = data;
    e.last = last;
    expQ.push_back(e);
    if (!modelLocked) modelRoute = sel;
    modelLocked = !last;
  endtask

  task automatic popCompare(input int chan);
    int idx;
    idx = -1;
    foreach (expQ[k]) begin
      if (idx < 0 && expQ[k].chan == 2'(chan)) idx = k;
    end
    if (idx < 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL sbUnexpected ch%0d: got data 0x%0h, expected no beat", chan, m_data[chan]);
    end else begin
      checkOutput($sformatf("sbData ch%0d", chan), 32'(m_data[chan]), 32'(expQ[idx].data));
      checkOutput($sformatf("sbLast ch%0d", chan), 32'(m_last[chan]), 32'(expQ[idx].last));
      expQ.delete(idx);
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, pop on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (prevStall[i]) begin
          checkOutput($sformatf("holdValid ch%0d", i), 32'(m_valid[i]), 32'd1);
          checkOutput($sformatf("holdData ch%0d", i), 32'(m_data[i]), 32'(prevData[i]));
          checkOutput($sformatf("holdLast ch%0d", i), 32'(m_last[i]), 32'(prevLast[i]));
        end
        if (m_valid[i] && m_ready[i]) popCompare(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      prevStall[i] = rst_n && m_valid[i] && !m_ready[i];
      prevData[i]  = m_data[i];
      prevLast[i]  = m_last[i];
    end
  end

  // Drive one table row and check the registered result one cycle later.
  task automatic applyStimulus(input vec_t v);
    s_valid = 1'b1;
    s_sel   = v.sel;
    s_data  = v.data;
    s_last  = v.last;
    @(negedge clk);
    checkOutput("tableReady", 32'(s_ready), 32'd1);
    if (s_ready) pushExpected(v.sel, v.data, v.last);
    @(posedge clk);
    #1;
    checkOutput("tableValid", 32'(m_valid), 32'(4'b0001 << v.expChan));
    checkOutput("tableData", 32'(m_data[v.expChan]), 32'(v.data));
    checkOutput("tableLast", 32'(m_last[v.expChan]), 32'(v.last));
    checkOutput("tableBusy", 32'(busy), 32'(v.expBusy));
  endtask

  // Present a beat until accepted, bounded; returns just after the accepting edge.
  task automatic sendBeat(input logic [1:0] sel, input logic [7:0] data, input logic last);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("sendReady", 32'(s_ready), 32'd1);
    if (s_ready) pushExpected(sel, data, last);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'd0, 8'hA0, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{2'd1, 8'hA1, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{2'd2, 8'hA2, 1'b1, 2'd2, 1'b0};
    vecs[3]  = '{2'd3, 8'hA3, 1'b1, 2'd3, 1'b0};
    vecs[4]  = '{2'd2, 8'h11, 1'b0, 2'd2, 1'b1};
    vecs[5]  = '{2'd0, 8'h22, 1'b0, 2'd2, 1'b1};
    vecs[6]  = '{2'd1, 8'h33, 1'b1, 2'd2, 1'b0};
    for (int i = 0; i < 8; i++) begin
      vecs[7+i] = '{2'd0, 8'(8'h40 + 8'(i * 7)), (i == 7), 2'd0, (i != 7)};
    end

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sel   = 2'd0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", 32'(m_valid), 32'd0);
    checkOutput("rstLast", 32'(m_last), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rstData%0d", i), 32'(m_data[i]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] table: single-beat routing, packet lock, full-rate channel 0");
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("tableDrained", 32'(m_valid), 32'd0);

    $display("[TB] backpressure isolation on channel 1");
    m_ready = 4'b1101;
    sendBeat(2'd1, 8'h55, 1'b1);
    checkOutput("bpLoad55", 32'(m_data[1]), 32'h55);
    s_valid = 1'b1;
    s_sel   = 2'd1;
    s_data  = 8'h66;
    s_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("bpReadyLow", 32'(s_ready), 32'd0);
      checkOutput("bpHold55", 32'(m_data[1]), 32'h55);
    end
    @(posedge clk);
    #1;
    m_ready = 4'hF;
    @(negedge clk);
    checkOutput("bpReadyHigh", 32'(s_ready), 32'd1);
    if (s_ready) pushExpected(2'd1, 8'h66, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bpLoad66", 32'(m_data[1]), 32'h66);
    checkOutput("bpValid1", 32'(m_valid[1]), 32'd1);
    sendBeat(2'd3, 8'h77, 1'b1);
    checkOutput("bpValid3", 32'(m_valid[3]), 32'd1);
    checkOutput("bpData77", 32'(m_data[3]), 32'h77);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a packet");
    sendBeat(2'd3, 8'hC1, 1'b0);
    sendBeat(2'd3, 8'hC2, 1'b0);
    checkOutput("midBusy", 32'(busy), 32'd1);
    checkOutput("midData", 32'(m_data[3]), 32'hC2);
    m_ready = 4'b0111;
    rst_n   = 1'b0;
    expQ.delete();
    modelLocked = 1'b0;
    modelRoute  = 2'd0;
    @(posedge clk);
    #1;
    checkOutput("midRstValid", 32'(m_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    rst_n   = 1'b1;
    m_ready = 4'hF;
    sendBeat(2'd1, 8'hD1, 1'b0);
    checkOutput("afterRstValid", 32'(m_valid), 32'b0010);
    checkOutput("afterRstBusy", 32'(busy), 32'd1);
    sendBeat(2'd3, 8'hD2, 1'b1);
    checkOutput("afterRstLock", 32'(m_valid), 32'b0010);
    checkOutput("afterRstData", 32'(m_data[1]), 32'hD2);
    checkOutput("afterRstIdle", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_stream_demux_1to4
